rx_frame_ctrl: RTL
==================

# rx_frame_ctrl

Sequencing controller for the UART receive path of the AES-over-UART link. It accepts byte strobes from the UART byte receiver and shifts exactly one frame (payload plus CRC) into the frame receiver. It then raises `crc_en` and waits a bounded time for the receiver's `valid`, and hands the 112-bit payload to the AES core over a valid/ready handshake. Malformed frames (CRC timeout, inter-byte gap) are aborted cleanly, and the controller re-arms for the next frame.

## Interface
- `FRAME_BYTES`, 16, bytes per frame (14 payload + 2 CRC); range 2..255.
- `CRC_WAIT`, 8, cycles allowed from `crc_en` rise to `rx_valid`; ≥1.
- `GAP_TIMEOUT`, 1024, idle cycles tolerated between bytes inside a frame; ≥2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `byte_valid`  in  1  one-cycle strobe: `byte_in` holds a received UART byte.
- `byte_in`  in  8  received byte.
- `rx_byte`  out  8  registered byte driven to the receiver's `serial_in`.
- `rx_shift`  out  1  one-cycle strobe: the receiver captures `rx_byte` this cycle.
- `crc_en`  out  1  level; high while the controller awaits the CRC result.
- `rx_valid`  in  1  receiver CRC-pass indication.
- `rx_data`  in  112  receiver payload.
- `aes_valid`  out  1  payload available to the AES core.
- `aes_data`  out  112  registered payload.
- `aes_ready`  in  1  AES core accepts the payload.
- `busy`  out  1  high in every state except IDLE.
- `frame_err`  out  1  one-cycle pulse on any aborted frame.
- `err_cnt`  out  8  saturating error count; present only with `RX_ERR_CNT_EN`.

## Operation
- FSM states: IDLE, COLLECT, CHECK, OUT.
- IDLE:
  - On `byte_valid`: register `byte_in` into `rx_byte`, pulse `rx_shift`, set `byte_cnt`=1, go to COLLECT.
- COLLECT:
  - On each `byte_valid`: register, pulse, increment `byte_cnt`, clear `gap_cnt`.
  - When `byte_cnt` reaches `FRAME_BYTES`, go to CHECK.
  - With no byte, `gap_cnt` increments. At `gap_cnt`==`GAP_TIMEOUT`: pulse `frame_err`, clear counters, go to IDLE.
- CHECK:
  - `crc_en`=1 and `wait_cnt` increments.
  - On `rx_valid`=1: latch `rx_data` into `aes_data`, go to OUT.
  - At `wait_cnt`==`CRC_WAIT` without `rx_valid`: pulse `frame_err`, go to IDLE.
  - `rx_valid` on the same cycle the timeout expires counts as a pass.
- OUT:
  - `aes_valid`=1 and `aes_data` holds stable until `aes_valid` and `aes_ready` are both high. Then go to IDLE.
- Bytes arriving in CHECK or OUT are dropped, not forwarded. With the macro enabled, each dropped byte counts as an error; no `frame_err` pulse.
- Counter widths: `byte_cnt` is `$clog2(FRAME_BYTES+1)`, `gap_cnt` is `$clog2(GAP_TIMEOUT+1)`, `wait_cnt` is `$clog2(CRC_WAIT+1)`. None of them wraps.
- Reset (async, any state): state=IDLE; all counters=0; `rx_byte`=0, `rx_shift`=0, `crc_en`=0, `aes_valid`=0, `aes_data`=0, `busy`=0, `frame_err`=0, `err_cnt`=0.

## Timing
- `byte_valid` at cycle N gives `rx_byte`/`rx_shift` at cycle N+1.
- Last byte at cycle N gives `crc_en`=1 from N+2 (CHECK entry).
- `rx_valid` at cycle M gives `aes_valid`=1 and new `aes_data` at M+1. `crc_en` is 0 at M+1.
- Handshake completes at cycle K. `aes_valid`=0 at K+1, and a byte at K+1 is accepted from IDLE.
- `frame_err` is high for exactly the cycle after the abort condition.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `RX_ERR_CNT_EN` defined:
  - `err_cnt` port exists.
  - It increments by 1 per gap abort, CRC timeout or dropped byte, and saturates at 255.
  - Simultaneous events in one cycle add 1 only.
- `RX_ERR_CNT_EN` undefined: the `err_cnt` port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `aes_uart_pkg`:
  - FSM state enum `rx_ctrl_state_t`.
  - Constants `PAYLOAD_W`=112 and `FRAME_W`=128.
  - Default parameter values.
- One natural sub-module, `rx_timeout_cnt`: a loadable saturating down-counter with an expire flag. It is instantiated twice, for the gap and CRC timers.

## Test plan
- Good frame:
  - Stimulus: send bytes 1d 5a 66 21 52 7f 5b 22 6b f0 e9 72 05 a6 6a 71 one per cycle, then `rx_valid`=1 three cycles after `crc_en` rises. `aes_ready`=1.
  - Required: 16 `rx_shift` pulses in order; `aes_valid` one cycle after `rx_valid`, with `aes_data`==`rx_data`; back in IDLE.
- Back-pressure:
  - Stimulus: as above with `aes_ready`=0 for 20 cycles.
  - Required: `aes_valid` and `aes_data` stable for all 20 cycles; bytes sent meanwhile are dropped (`err_cnt`+n with the macro).
- CRC timeout:
  - Stimulus: 16 bytes, `rx_valid` held 0.
  - Required: `crc_en` high for exactly 8 cycles, one `frame_err` pulse, IDLE, `err_cnt`=1.
- Gap abort:
  - Stimulus: 5 bytes, then 1024 idle cycles.
  - Required: `frame_err` pulse; the next 16 bytes form a complete good frame.
- Reset mid-frame:
  - Stimulus: drop `reset` after 9 bytes.
  - Required: all outputs at reset values immediately (asynchronously); a fresh 16-byte frame succeeds.
- Saturation (macro on):
  - Stimulus: 300 CRC timeouts.
  - Required: `err_cnt`==255.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES-over-UART receive path.
package aes_uart_pkg;

  localparam int unsigned PAYLOAD_W = 112;
  localparam int unsigned FRAME_W   = 128;

  localparam int unsigned FRAME_BYTES_DEF = 16;
  localparam int unsigned CRC_WAIT_DEF    = 8;
  localparam int unsigned GAP_TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StCheck   = 2'd2,
    StOut     = 2'd3
  } rx_ctrl_state_t;

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// Signal bundle between rx_frame_ctrl and its byte source, frame receiver and AES core.
// err_cnt exists only when RX_ERR_CNT_EN is defined.
interface rx_frame_ctrl_if;
  import aes_uart_pkg::*;

  logic                 byte_valid;
  logic [7:0]           byte_in;
  logic [7:0]           rx_byte;
  logic                 rx_shift;
  logic                 crc_en;
  logic                 rx_valid;
  logic [PAYLOAD_W-1:0] rx_data;
  logic                 aes_valid;
  logic [PAYLOAD_W-1:0] aes_data;
  logic                 aes_ready;
  logic                 busy;
  logic                 frame_err;
`ifdef RX_ERR_CNT_EN
  logic [7:0]           err_cnt;
`endif

  modport master (
`ifdef RX_ERR_CNT_EN
    output err_cnt,
`endif
    input  byte_valid, byte_in, rx_valid, rx_data, aes_ready,
    output rx_byte, rx_shift, crc_en, aes_valid, aes_data, busy, frame_err
  );

  modport slave (
`ifdef RX_ERR_CNT_EN
    input  err_cnt,
`endif
    output byte_valid, byte_in, rx_valid, rx_data, aes_ready,
    input  rx_byte, rx_shift, crc_en, aes_valid, aes_data, busy, frame_err
  );

endinterface

// File: rtl/rx_timeout_cnt.sv
// Loadable saturating down-counter; o_expire flags that the next enabled cycle is the last one.
module rx_timeout_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_expire = (r_cnt == WIDTH'(1));

endmodule

// File: rtl/rx_frame_ctrl.sv
// UART receive sequencer: shifts one frame into the receiver, waits for CRC, hands payload to AES.
// Optional saturating error counter enabled by RX_ERR_CNT_EN.
module rx_frame_ctrl
  import aes_uart_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int unsigned CRC_WAIT    = CRC_WAIT_DEF,
  parameter int unsigned GAP_TIMEOUT = GAP_TIMEOUT_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  rx_frame_ctrl_if.master io_bus
);

  localparam int unsigned ByteW = $clog2(FRAME_BYTES + 1);
  localparam int unsigned GapW  = $clog2(GAP_TIMEOUT + 1);
  localparam int unsigned WaitW = $clog2(CRC_WAIT + 1);

  localparam logic [ByteW-1:0] ByteLast = ByteW'(FRAME_BYTES);

  rx_ctrl_state_t       r_state, w_state_d;
  logic [ByteW-1:0]     r_byte_cnt, w_byte_cnt_d;
  logic                 w_accept, w_gap_en, w_gap_exp, w_gap_abort;
  logic                 w_wait_load, w_wait_en, w_wait_exp, w_crc_abort, w_crc_pass;
  logic [7:0]           r_rx_byte;
  logic                 r_rx_shift, r_crc_en, r_aes_valid, r_busy, r_frame_err;
  logic [PAYLOAD_W-1:0] r_aes_data;

  rx_timeout_cnt #(.WIDTH(GapW)) u_gap_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_accept),
    .i_load_val (GapW'(GAP_TIMEOUT)),
    .i_en       (w_gap_en),
    .o_expire   (w_gap_exp)
  );

  rx_timeout_cnt #(.WIDTH(WaitW)) u_wait_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_wait_load),
    .i_load_val (WaitW'(CRC_WAIT)),
    .i_en       (w_wait_en),
    .o_expire   (w_wait_exp)
  );

  always_comb begin
    w_state_d    = r_state;
    w_byte_cnt_d = r_byte_cnt;
    w_accept     = 1'b0;
    w_gap_en     = 1'b0;
    w_gap_abort  = 1'b0;
    w_wait_load  = 1'b0;
    w_wait_en    = 1'b0;
    w_crc_abort  = 1'b0;
    w_crc_pass   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.byte_valid) begin
          w_accept     = 1'b1;
          w_byte_cnt_d = ByteW'(1);
          w_state_d    = StCollect;
        end
      end
      StCollect: begin
        // The frame is complete one cycle before CHECK; a byte arriving here is dropped.
        if (r_byte_cnt == ByteLast) begin
          w_wait_load  = 1'b1;
          w_byte_cnt_d = '0;
          w_state_d    = StCheck;
        end else if (io_bus.byte_valid) begin
          w_accept     = 1'b1;
          w_byte_cnt_d = r_byte_cnt + ByteW'(1);
        end else begin
          w_gap_en = 1'b1;
          if (w_gap_exp) begin
            w_gap_abort  = 1'b1;
            w_byte_cnt_d = '0;
            w_state_d    = StIdle;
          end
        end
      end
      StCheck: begin
        w_wait_en = 1'b1;
        if (io_bus.rx_valid) begin
          w_crc_pass = 1'b1;
          w_state_d  = StOut;
        end else if (w_wait_exp) begin
          w_crc_abort = 1'b1;
          w_state_d   = StIdle;
        end
      end
      StOut: begin
        if (io_bus.aes_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_byte_cnt  <= '0;
      r_rx_byte   <= '0;
      r_rx_shift  <= 1'b0;
      r_crc_en    <= 1'b0;
      r_aes_valid <= 1'b0;
      r_aes_data  <= '0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_byte_cnt  <= w_byte_cnt_d;
      r_rx_shift  <= w_accept;
      r_crc_en    <= (w_state_d == StCheck);
      r_aes_valid <= (w_state_d == StOut);
      r_busy      <= (w_state_d != StIdle);
      r_frame_err <= w_gap_abort | w_crc_abort;
      if (w_accept)   r_rx_byte  <= io_bus.byte_in;
      if (w_crc_pass) r_aes_data <= io_bus.rx_data;
    end
  end

  assign io_bus.rx_byte   = r_rx_byte;
  assign io_bus.rx_shift  = r_rx_shift;
  assign io_bus.crc_en    = r_crc_en;
  assign io_bus.aes_valid = r_aes_valid;
  assign io_bus.aes_data  = r_aes_data;
  assign io_bus.busy      = r_busy;
  assign io_bus.frame_err = r_frame_err;

`ifdef RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  logic       w_err_evt;

  // Any byte not forwarded while busy is a drop; coincident events count once.
  assign w_err_evt = w_gap_abort | w_crc_abort | (io_bus.byte_valid & ~w_accept);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_err_cnt <= '0;
    end else if (w_err_evt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign io_bus.err_cnt = r_err_cnt;
`endif

endmodule
